eth4to1_pll_rst_ctrl: RTL
=========================

Name: eth4to1_pll_rst_ctrl

Overview:
Reset/lock sequencer for the eth4to1 fabric PLL, which generates the 312.5 MHz and 260.416 MHz clocks from the 156.25 MHz reference. It pulses the PLL reset, waits for lock with a timeout, debounces lock, and holds the downstream datapath in reset until the clocks are trustworthy. It re-sequences automatically on lock loss and latches a failure flag after repeated timeouts. It runs on the free-running 156.25 MHz reference clock.

Parameters:
RST_CYCLES, 16, PLL reset pulse width in refclk cycles (16 cycles = 102 ns); minimum 1.
LOCK_TIMEOUT, 65536, maximum cycles spent in WAIT_LOCK before a retry.
LOCK_STABLE, 1024, consecutive synchronized-lock cycles required before ready.
MAX_RETRIES, 3, number of lock timeouts before entering FAIL; minimum 1.
SYNC_STAGES, 2, flop depth of the synchronizer on pll_locked; minimum 2.

Ports:
refclk  in  1  sole clock, 156.25 MHz reference.
rst  in  1  synchronous, active-high reset.
restart  in  1  single-cycle request to re-sequence the PLL from any state.
pll_locked  in  1  PLL locked output; asynchronous to refclk.
pll_rst  out  1  drives the PLL rst input.
pll_ready  out  1  high while the PLL is locked and debounced.
dp_rst  out  1  datapath reset; always equal to ~pll_ready.
fail  out  1  sticky failure flag.
retry_cnt  out  $clog2(MAX_RETRIES+1)  timeouts since the last successful lock or restart.
lock_loss_cnt  out  8  count of lock losses seen in READY; saturates at 255.
state  out  3  current FSM state encoding, for debug.

Behaviour:
- All outputs are registered. Reset is synchronous and active-high on refclk.
- Reset values: state=RESET_PLL, pll_rst=1, pll_ready=0, dp_rst=1, fail=0, retry_cnt=0, lock_loss_cnt=0, cycle counter=0.
- lock_s is pll_locked passed through the SYNC_STAGES-deep synchronizer. Every decision below uses lock_s only.
- RESET_PLL: pll_rst=1. After RST_CYCLES cycles in this state, go to WAIT_LOCK and clear the counter. pll_rst deasserts on the same edge as the state change.
- WAIT_LOCK: pll_rst=0.
  - If lock_s=1, go to STABILIZE and clear the counter.
  - Else, if the counter reaches LOCK_TIMEOUT-1, increment retry_cnt. If the new retry_cnt equals MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL.
- STABILIZE:
  - If lock_s=0, return to WAIT_LOCK with the counter cleared. retry_cnt is unchanged; a glitch is not a timeout.
  - Otherwise, after LOCK_STABLE consecutive lock_s=1 cycles in this state, go to READY. pll_ready=1 and dp_rst=0 on that edge. retry_cnt is cleared.
- READY: pll_ready=1. When lock_s=0:
  - pll_ready drops and dp_rst rises on the next edge;
  - lock_loss_cnt increments (saturating at 255);
  - go to RESET_PLL.
  - Worst-case detection latency from pll_locked falling is SYNC_STAGES+1 cycles.
- FAIL: pll_rst=1 (held), fail=1, pll_ready=0. pll_locked is ignored. Only restart or rst leaves this state.
- restart=1 in any state: go to RESET_PLL, clear retry_cnt, fail and the counter. lock_loss_cnt is preserved.
- Priority, highest first: rst > restart > lock/timeout events.
- Lock and timeout conditions in the same cycle: lock wins.
- Counters: one shared cycle counter, width $clog2(max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)). It never wraps, because every terminal value forces a state change.

Decomposition:
- Package eth4to1_pll_ctrl_pkg holds:
  - the state enum: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, READY=3, FAIL=4;
  - the lock_loss_cnt width constant (8);
  - a counter-width function.
- Sub-module eth4to1_bit_sync: a parameterized SYNC_STAGES flop chain, reset to 0 by the synchronous rst, used for pll_locked.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE=8, MAX_RETRIES=2, SYNC_STAGES=2.
1. Normal lock: rst released -> pll_rst=1 for exactly 4 cycles. Drive pll_locked=1 10 cycles after pll_rst falls -> pll_ready and ~dp_rst rise exactly 2+8=10 edges after the first edge sampling pll_locked=1; retry_cnt=0.
2. Lock glitch: pll_locked high for 3 cycles then low during STABILIZE -> state returns to WAIT_LOCK, pll_ready stays 0, retry_cnt stays 0. A later stable lock -> READY.
3. Timeout/fail: pll_locked held 0 -> pll_rst pulses 4 cycles wide with 32-cycle gaps; retry_cnt goes 1 then 2; after the second timeout fail=1, pll_rst is held 1 and state=FAIL. Asserting pll_locked=1 in FAIL -> no change.
4. Lock loss: in READY, drop pll_locked -> pll_ready=0 and dp_rst=1 within 3 cycles, lock_loss_cnt=1, a 4-cycle pll_rst pulse, then re-lock reaches READY. Repeat 256 losses -> lock_loss_cnt stays at 255.
5. Restart: pulse restart in FAIL -> next cycle state=RESET_PLL, fail=0, retry_cnt=0, lock_loss_cnt unchanged. Pulse restart in READY -> pll_ready=0 next cycle, lock_loss_cnt unchanged.
6. Reset mid-operation: assert rst during STABILIZE (cycle 5 of 8), together with restart=1 -> next cycle all outputs equal their reset values and lock_loss_cnt=0.

Source files
------------

// File: rtl/eth4to1_pll_ctrl_pkg.sv
// Shared types and sizing helpers for the eth4to1 fabric PLL reset/lock sequencer.
package eth4to1_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        READY     = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    localparam int LOSS_CNT_W = 8;

    // Width of the shared cycle counter: wide enough for the longest terminal count, never zero.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/eth4to1_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level; latency STAGES cycles, no flow control.
module eth4to1_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/eth4to1_pll_rst_ctrl.sv
// PLL reset/lock sequencer on the free-running reference clock; all outputs registered,
// lock-loss seen SYNC_STAGES+1 cycles after pll_locked falls; no flow control.
module eth4to1_pll_rst_ctrl
    import eth4to1_pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               refclk,
    input  logic                               rst,
    input  logic                               restart,
    input  logic                               pll_locked,
    output logic                               pll_rst,
    output logic                               pll_ready,
    output logic                               dp_rst,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [LOSS_CNT_W-1:0]              lock_loss_cnt,
    output logic [2:0]                         state
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    pll_state_e             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          retry_q, retry_d, retry_inc;
    logic [LOSS_CNT_W-1:0]  loss_q, loss_d;
    logic                   pll_rst_d, pll_ready_d, fail_d;
    logic                   lock_s;

    eth4to1_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk  (refclk),
        .rst  (rst),
        .din  (pll_locked),
        .dout (lock_s)
    );

    assign retry_inc = retry_q + 1'b1;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst   <= 1'b1;
            pll_ready <= 1'b0;
            dp_rst    <= 1'b1;
            fail      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst   <= pll_rst_d;
            pll_ready <= pll_ready_d;
            dp_rst    <= ~pll_ready_d;
            fail      <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (restart) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock takes precedence over a timeout landing on the same cycle.
                    if (lock_s) begin
                        state_d = STABILIZE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? FAIL : RESET_PLL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABILIZE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = READY;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY: begin
                    if (!lock_s) begin
                        state_d = RESET_PLL;
                        cnt_d   = '0;
                        loss_d  = (loss_q != '1) ? loss_q + 1'b1 : loss_q;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAIL);
        pll_ready_d = (state_d == READY);
        fail_d      = (state_d == FAIL);
    end

    assign state         = state_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule
